// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/writeback stage: control encodings and default widths.
package alu_pkg;

    localparam int unsigned CtrlWidth       = 3;
    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefNregs        = 16;
    localparam int unsigned DefRegAddrWidth = 4;

    typedef enum logic [CtrlWidth-1:0] {
        AluId0 = 3'd0,
        AluAdd = 3'd1,
        AluSub = 3'd2,
        AluEq  = 3'd3,
        AluLe  = 3'd4,
        AluGe  = 3'd5,
        AluId1 = 3'd6
    } alu_ctrl_e;

endpackage

// File: rtl/alu_regfile.sv
// Two-read/one-write register file with r0 hardwired to zero and write-port bypass on reads.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned NREGS          = DefNregs,
    parameter int unsigned REG_ADDR_WIDTH = DefRegAddrWidth
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REG_ADDR_WIDTH-1:0] raddr0_i,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1_i,
    output logic [DATA_WIDTH-1:0]     rdata0_o,
    output logic [DATA_WIDTH-1:0]     rdata1_o,
    input  logic                      we_i,
    input  logic [REG_ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i
);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // An in-flight writeback to the same register wins over the stored value.
    always_comb begin
        if (raddr0_i == '0) begin
            rdata0_o = '0;
        end else if (we_i && (waddr_i == raddr0_i)) begin
            rdata0_o = wdata_i;
        end else begin
            rdata0_o = regs_q[raddr0_i];
        end

        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch (S1) and control/writeback (S2) stage around an ALU that registers only its operands.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DefDataWidth,
    parameter int unsigned NREGS          = DefNregs,
    parameter int unsigned REG_ADDR_WIDTH = DefRegAddrWidth
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [CtrlWidth-1:0]      instr_ctrl,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs0,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rs1,
    input  logic [DATA_WIDTH-1:0]     instr_imm,
    input  logic                      instr_imm_sel,
    input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
    input  logic                      instr_we,
    output logic [CtrlWidth-1:0]      alu_ctrl,
    output logic [DATA_WIDTH-1:0]     alu_in0,
    output logic [DATA_WIDTH-1:0]     alu_in1,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]     wb_data
);

    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_we_q, s1_we_d;
    logic [REG_ADDR_WIDTH-1:0] s1_rd_q, s1_rd_d;
    alu_ctrl_e                 s1_ctrl_q, s1_ctrl_d;
    logic                      s2_valid_q, s2_valid_d;
    logic                      s2_we_q, s2_we_d;
    logic [REG_ADDR_WIDTH-1:0] s2_rd_q, s2_rd_d;
    alu_ctrl_e                 s2_ctrl_q, s2_ctrl_d;
    logic [DATA_WIDTH-1:0]     alu_in0_q, alu_in0_d;
    logic [DATA_WIDTH-1:0]     alu_in1_q, alu_in1_d;

    logic [DATA_WIDTH-1:0]     rdata0, rdata1;
    logic                      hazard;
    logic                      accept;

    alu_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NREGS          (NREGS),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (rstn),
        .raddr0_i (instr_rs0),
        .raddr1_i (instr_rs1),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1),
        .we_i     (wb_valid),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Producer still in S1 has no result yet; s1_we_q already excludes rd == 0.
    always_comb begin
        hazard = s1_valid_q && s1_we_q &&
                 ((s1_rd_q == instr_rs0) || (!instr_imm_sel && (s1_rd_q == instr_rs1)));
    end

    assign instr_ready = !hazard;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        s1_valid_d = accept;
        s1_we_d    = accept && instr_we && (instr_rd != '0);
        s1_rd_d    = s1_rd_q;
        s1_ctrl_d  = s1_ctrl_q;
        alu_in0_d  = alu_in0_q;
        alu_in1_d  = alu_in1_q;
        if (accept) begin
            s1_rd_d   = instr_rd;
            s1_ctrl_d = alu_ctrl_e'(instr_ctrl);
            alu_in0_d = rdata0;
            alu_in1_d = instr_imm_sel ? instr_imm : rdata1;
        end

        s2_valid_d = s1_valid_q;
        s2_we_d    = s1_we_q;
        s2_rd_d    = s1_rd_q;
        s2_ctrl_d  = s1_ctrl_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_rd_q    <= '0;
            s1_ctrl_q  <= AluId0;
            s2_valid_q <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_rd_q    <= '0;
            s2_ctrl_q  <= AluId0;
            alu_in0_q  <= '0;
            alu_in1_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_we_q    <= s1_we_d;
            s1_rd_q    <= s1_rd_d;
            s1_ctrl_q  <= s1_ctrl_d;
            s2_valid_q <= s2_valid_d;
            s2_we_q    <= s2_we_d;
            s2_rd_q    <= s2_rd_d;
            s2_ctrl_q  <= s2_ctrl_d;
            alu_in0_q  <= alu_in0_d;
            alu_in1_q  <= alu_in1_d;
        end
    end

    assign alu_ctrl = s2_ctrl_q;
    assign alu_in0  = alu_in0_q;
    assign alu_in1  = alu_in1_q;
    assign wb_valid = s2_valid_q && s2_we_q;
    assign wb_addr  = s2_rd_q;
    assign wb_data  = alu_out;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural ALU closing the loop on alu_out.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_ctrl = '0;
    logic [3:0]  instr_rs0 = '0;
    logic [3:0]  instr_rs1 = '0;
    logic [31:0] instr_imm = '0;
    logic        instr_imm_sel = 1'b0;
    logic [3:0]  instr_rd = '0;
    logic        instr_we = 1'b0;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_ctrl    (instr_ctrl),
        .instr_rs0     (instr_rs0),
        .instr_rs1     (instr_rs1),
        .instr_imm     (instr_imm),
        .instr_imm_sel (instr_imm_sel),
        .instr_rd      (instr_rd),
        .instr_we      (instr_we),
        .alu_ctrl      (alu_ctrl),
        .alu_in0       (alu_in0),
        .alu_in1       (alu_in1),
        .alu_out       (alu_out),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data)
    );

    // ALU: operands registered, control combinational.
    logic [31:0] a0_q, a1_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a0_q <= '0;
            a1_q <= '0;
        end else begin
            a0_q <= alu_in0;
            a1_q <= alu_in1;
        end
    end

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            3'd0: alu_out = a0_q;
            3'd1: alu_out = a0_q + a1_q;
            3'd2: alu_out = a0_q - a1_q;
            3'd3: alu_out = {31'd0, a0_q == a1_q};
            3'd4: alu_out = {31'd0, $signed(a0_q) <= $signed(a1_q)};
            3'd5: alu_out = {31'd0, $signed(a0_q) >= $signed(a1_q)};
            3'd6: alu_out = a1_q;
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] ctrl, input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [31:0] imm, input logic imm_sel, input logic [3:0] rd,
                         input logic we);
        instr_valid   = 1'b1;
        instr_ctrl    = ctrl;
        instr_rs0     = rs0;
        instr_rs1     = rs1;
        instr_imm     = imm;
        instr_imm_sel = imm_sel;
        instr_rd      = rd;
        instr_we      = we;
        #1;
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        instr_we    = 1'b0;
        instr_rs0   = '0;
        instr_rs1   = '0;
        instr_rd    = '0;
        #1;
    endtask

    initial begin
        // Reset held for three edges
        repeat (3) tick();
        rstn = 1'b1;
        #1;
        chk("rst_alu_in0", alu_in0, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_addr", {28'd0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);

        // Load immediate r1 = 5
        issue(3'd6, 4'd0, 4'd0, 32'd5, 1'b1, 4'd1, 1'b1);
        chk("li_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        chk("li_in1", alu_in1, 32'd5);
        chk("li_ctrl_lag", {29'd0, alu_ctrl}, 32'd0);
        chk("li_wbv_early", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("li_ctrl", {29'd0, alu_ctrl}, 32'd6);
        chk("li_wbv", {31'd0, wb_valid}, 32'd1);
        chk("li_wba", {28'd0, wb_addr}, 32'd1);
        chk("li_wbd", wb_data, 32'd5);
        tick();
        chk("li_wbv_done", {31'd0, wb_valid}, 32'd0);

        // Distance-1: r6 = 5 then r2 = r6 + 3
        issue(3'd6, 4'd0, 4'd0, 32'd5, 1'b1, 4'd6, 1'b1);
        tick();
        issue(3'd1, 4'd6, 4'd0, 32'd3, 1'b1, 4'd2, 1'b1);
        chk("d1_stall", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("d1_stall_once", {31'd0, instr_ready}, 32'd1);
        chk("d1_prod_wbd", wb_data, 32'd5);
        tick();
        idle();
        chk("d1_bubble_wbv", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("d1_wbv", {31'd0, wb_valid}, 32'd1);
        chk("d1_wba", {28'd0, wb_addr}, 32'd2);
        chk("d1_wbd", wb_data, 32'd8);
        tick();

        // Distance-2: r7 = 5, r8 = 100, r9 = r7 - 2
        issue(3'd6, 4'd0, 4'd0, 32'd5, 1'b1, 4'd7, 1'b1);
        tick();
        issue(3'd6, 4'd0, 4'd0, 32'd100, 1'b1, 4'd8, 1'b1);
        chk("d2_ready_a", {31'd0, instr_ready}, 32'd1);
        tick();
        issue(3'd2, 4'd7, 4'd0, 32'd2, 1'b1, 4'd9, 1'b1);
        chk("d2_ready_b", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        chk("d2_mid_wbd", wb_data, 32'd100);
        tick();
        chk("d2_wba", {28'd0, wb_addr}, 32'd9);
        chk("d2_wbd", wb_data, 32'd3);
        tick();

        // r0 write dropped, then r10 = r0
        issue(3'd6, 4'd0, 4'd0, 32'd7, 1'b1, 4'd0, 1'b1);
        tick();
        issue(3'd0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd10, 1'b1);
        chk("r0_no_stall", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        chk("r0_wbv", {31'd0, wb_valid}, 32'd0);
        tick();
        chk("r0_rd_wbv", {31'd0, wb_valid}, 32'd1);
        chk("r0_rd_wbd", wb_data, 32'd0);
        tick();

        // Signed compare: r3 = -1, r11 = (r3 <= 1)
        issue(3'd6, 4'd0, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'd3, 1'b1);
        tick();
        issue(3'd4, 4'd3, 4'd0, 32'd1, 1'b1, 4'd11, 1'b1);
        chk("le_stall", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("le_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        tick();
        chk("le_wba", {28'd0, wb_addr}, 32'd11);
        chk("le_wbd", wb_data, 32'd1);
        tick();

        // Register-register with rs1 hazard: r13 = 20, r14 = r2 + r13
        issue(3'd6, 4'd0, 4'd0, 32'd20, 1'b1, 4'd13, 1'b1);
        tick();
        issue(3'd1, 4'd2, 4'd13, 32'd0, 1'b0, 4'd14, 1'b1);
        chk("rs1_stall", {31'd0, instr_ready}, 32'd0);
        tick();
        chk("rs1_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        tick();
        chk("rs1_wba", {28'd0, wb_addr}, 32'd14);
        chk("rs1_wbd", wb_data, 32'd28);
        tick();

        // Immediate operand ignores rs1 hazard
        issue(3'd6, 4'd0, 4'd0, 32'd1, 1'b1, 4'd15, 1'b1);
        tick();
        issue(3'd1, 4'd2, 4'd15, 32'd1, 1'b1, 4'd12, 1'b1);
        chk("imm_no_stall", {31'd0, instr_ready}, 32'd1);
        tick();
        idle();
        tick();
        tick();
        chk("imm_wbd", wb_data, 32'd9);
        tick();

        // Reset mid-operation: r4 = 9 accepted, then reset
        issue(3'd6, 4'd0, 4'd0, 32'd9, 1'b1, 4'd4, 1'b1);
        tick();
        idle();
        rstn = 1'b0;
        tick();
        chk("mr_wbv_rst", {31'd0, wb_valid}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("mr_wbv_after", {31'd0, wb_valid}, 32'd0);
        issue(3'd0, 4'd4, 4'd0, 32'd0, 1'b1, 4'd5, 1'b1);
        tick();
        idle();
        tick();
        chk("mr_rd_wbv", {31'd0, wb_valid}, 32'd1);
        chk("mr_rd_r4", wb_data, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch and writeback stage wrapped around the ALU.
- Accepts decoded ALU instructions from the issue logic and reads two operands from a local register file. An immediate can replace the second operand.
- Drives the ALU's operand and control inputs with correct timing, then writes the ALU result back to the register file.
- Handles read-after-write hazards with a one-cycle stall plus write bypass. It sits between instruction decode and the ALU in each processor core.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NREGS, 16, number of registers; r0 reads as zero.
- REG_ADDR_WIDTH, 4, register address width, equal to log2(NREGS).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rstn  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  stage can accept; transfer occurs when instr_valid & instr_ready.
- instr_ctrl  in  3  ALU operation code.
- instr_rs0  in  REG_ADDR_WIDTH  source register for in0.
- instr_rs1  in  REG_ADDR_WIDTH  source register for in1; ignored when instr_imm_sel=1.
- instr_imm  in  DATA_WIDTH  immediate value.
- instr_imm_sel  in  1  1: in1 = instr_imm.
- instr_rd  in  REG_ADDR_WIDTH  destination register.
- instr_we  in  1  write result to instr_rd.
- alu_ctrl  out  3  ALU control input.
- alu_in0  out  DATA_WIDTH  ALU operand 0.
- alu_in1  out  DATA_WIDTH  ALU operand 1.
- alu_out  in  DATA_WIDTH  ALU result (combinational from the ALU's registered inputs).
- wb_valid  out  1  writeback strobe this cycle.
- wb_addr  out  REG_ADDR_WIDTH  writeback register.
- wb_data  out  DATA_WIDTH  writeback data (equal to alu_out).

Behaviour:
- Clock and reset: single clock clk; reset rstn is synchronous and active-low.
- Reset values: alu_in0, alu_in1, alu_ctrl, wb_addr, wb_data = 0; wb_valid = 0; all registers = 0; pipeline valid bits cleared; instr_ready = 1 in the first cycle after reset release.
- The ALU registers its operands internally but not ctrl, so control must trail the operands by one cycle.
- Stage S1, at accept edge E0:
  - Register the operands onto alu_in0/alu_in1.
  - Latch ctrl, rd, and the effective write enable (we & rd!=0) into S1.
- Stage S2, at edge E1:
  - The ALU captures the operands.
  - The stage moves S1 into S2; S2 ctrl drives alu_ctrl.
  - alu_out is valid between E1 and E2.
- Writeback, during the E1–E2 cycle:
  - wb_valid = S2.valid & S2.we; wb_addr = S2.rd; wb_data = alu_out.
  - The register file write commits at E2.
- Latency: accept to register-file commit is 2 edges. Throughput is 1 instruction/cycle when there is no hazard.
- Bubbles: when no instruction is accepted, S1 is invalid and the operand registers hold their values. alu_ctrl still follows S2 and wb_valid = 0.
- Register file: combinational read.
  - Address 0 always reads 0; writes to r0 are dropped.
- Write bypass: if a read address equals wb_addr while wb_valid=1, the read returns wb_data. This covers dependency distance 2.
- Stall: instr_ready = 0 when S1.valid & S1.we, and S1.rd equals instr_rs0, or equals instr_rs1 while instr_imm_sel=0.
  - This is a distance-1 hazard. The result is not yet computed.
  - A stall lasts exactly one cycle. The next cycle the producer is in S2, and the bypass supplies the value.
  - During the stall, S1 becomes invalid (bubble).
- Immediate: instr_imm_sel=1 makes alu_in1 = instr_imm. No hazard check is applied on rs1.
- A hazard on rs0 with rd = 0 never stalls.
- Dependent instructions issued back-to-back therefore see one bubble. No downstream backpressure exists.
- Simultaneous writeback and read of the same register with no stall: the bypass value wins.
- Reset mid-operation: in-flight S1/S2 instructions are discarded. No writeback occurs on or after the reset edge, and registers clear.

Decomposition:
- Shared package alu_pkg:
  - ALU control encodings: ID0=0, ADD=1, SUB=2, EQ=3, LE=4, GE=5, ID1=6.
  - Default DATA_WIDTH and REG_ADDR_WIDTH.
- Sub-module alu_regfile: 2 read ports, 1 write port, r0 hardwired to zero, write bypass.
- Pipeline control and hazard logic stay in alu_operand_stage.

Test Plan:
- Reset: hold rstn=0 for 3 cycles, release -> all outputs 0, instr_ready=1, wb_valid=0.
- Load immediate: ctrl=6, imm=5, imm_sel=1, rd=1, we=1 -> alu_ctrl=6 one cycle after alu_in1=5; wb_valid=1, wb_addr=1, wb_data=5 two cycles after accept.
- Distance-1 dependency:
  - Stimulus: r1=5 issued, then next cycle ctrl=1, rs0=1, imm=3, rd=2.
  - Response: instr_ready=0 for exactly one cycle; wb_data=8 to r2 three cycles after the first accept.
- Distance-2 dependency:
  - Stimulus: r1=5, an unrelated instruction, then ctrl=2 rs0=1 imm=2.
  - Response: no stall; bypass yields wb_data=3.
- r0 and compare:
  - Write 7 to r0, then ctrl=0 rs0=0 -> wb_data=0, no stall.
  - r3=0xFFFFFFFF, then ctrl=4, rs0=3, imm=1 -> wb_data=1.
- Reset mid-operation: accept a write to r4=9, assert rstn=0 on the next edge -> no wb_valid; a later read of r4 returns 0.
